// File: rtl/lc3b_types.sv
`default_nettype none
// ============================================================================
//  Module   : lc3b_types (package)
//  Purpose  : Shared LC-3b datapath types: cache chunk widths and the
//             L2 cache controller state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package lc3b_types;

    typedef logic [127:0] lc3b_chunk;
    typedef logic [255:0] lc3b_full_chunk;

    // L2 controller states; two bits cover all four
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } lc3b_l2_state;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = '1;
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // count up on inc, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`default_nettype none
// ============================================================================
//  Module   : l2_cache_control
//  Purpose  : Control FSM for the 2-way set-associative L2 cache: hit
//             handling, dirty-victim writeback, line fill, and saturating
//             hit/miss/writeback statistics.
//  Revision : 1.0  initial release
// ============================================================================
module l2_cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit,
    input  logic                 hit_way,
    input  logic                 lru_way,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic                 pmem_resp,
    output logic                 route_hit,
    output logic [1:0]           way_write,
    output logic                 tag_load,
    output logic                 dirty_load,
    output logic                 dirty_in,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic                 pmem_addr_sel,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 mem_resp,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    lc3b_l2_state r_state;
    lc3b_l2_state w_next_state;
    logic         r_refill;     // current COMPARE is the re-check after a fill
    logic         w_req;
    logic         w_hit_inc;
    logic         w_miss_inc;
    logic         w_wb_inc;

    assign w_req = mem_read | mem_write;

    // state register and refill flag (flag cleared whenever we pass IDLE)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_refill <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE) begin
                r_refill <= 1'b0;
            end else if ((r_state == FILL) && pmem_resp) begin
                r_refill <= 1'b1;
            end
        end
    end

    // next-state and array/pmem control decoded from state plus inputs
    always_comb begin
        w_next_state  = r_state;
        route_hit     = 1'b1;
        way_write     = 2'b00;
        tag_load      = 1'b0;
        dirty_load    = 1'b0;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        mem_resp      = 1'b0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        w_wb_inc      = 1'b0;
        case (r_state)
            IDLE: begin
                // one cycle for the registered tag/data array read
                if (w_req) begin
                    w_next_state = COMPARE;
                end
            end
            COMPARE: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (hit) begin
                    mem_resp  = 1'b1;
                    lru_load  = 1'b1;
                    lru_in    = ~hit_way;
                    // a simultaneous read+write is handled as a write
                    if (mem_write) begin
                        way_write[hit_way] = 1'b1;
                        dirty_load         = 1'b1;
                        dirty_in           = 1'b1;
                    end
                    w_hit_inc    = ~r_refill;
                    w_next_state = IDLE;
                end else begin
                    w_miss_inc = ~r_refill;
                    if (victim_valid && victim_dirty) begin
                        w_next_state = WRITEBACK;
                    end else begin
                        w_next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    w_wb_inc     = 1'b1;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                route_hit = 1'b0;
                // install the line clean; any write merges on the re-compare
                if (pmem_resp) begin
                    way_write[lru_way] = 1'b1;
                    tag_load           = 1'b1;
                    dirty_load         = 1'b1;
                    dirty_in           = 1'b0;
                    w_next_state       = COMPARE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_miss_inc),
        .count (miss_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_wb_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wb_inc),
        .count (wb_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_cache_control
//  Purpose  : Self-checking bench for l2_cache_control: COMPARE-cycle vector
//             table, directed miss/saturation/reset sequences, and random
//             accesses against a behavioural 2-way cache model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_cache_control;

    localparam int CW  = 4;
    localparam int MAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_read, mem_write, hit, hit_way, lru_way;
    logic          victim_valid, victim_dirty, pmem_resp;
    logic          route_hit, tag_load, dirty_load, dirty_in, lru_load, lru_in;
    logic          pmem_addr_sel, pmem_read, pmem_write, mem_resp;
    logic [1:0]    way_write;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l2_cache_control #(.CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .hit           (hit),
        .hit_way       (hit_way),
        .lru_way       (lru_way),
        .victim_valid  (victim_valid),
        .victim_dirty  (victim_dirty),
        .pmem_resp     (pmem_resp),
        .route_hit     (route_hit),
        .way_write     (way_write),
        .tag_load      (tag_load),
        .dirty_load    (dirty_load),
        .dirty_in      (dirty_in),
        .lru_load      (lru_load),
        .lru_in        (lru_in),
        .pmem_addr_sel (pmem_addr_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .mem_resp      (mem_resp),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .wb_count      (wb_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {mem_resp, way_write, dirty_load, dirty_in, lru_load, lru_in,
                route_hit, tag_load, pmem_read, pmem_write, pmem_addr_sel};
    endfunction

    function automatic logic [11:0] expv(input logic rsp, input logic [1:0] ww,
            input logic dl, input logic di, input logic ll, input logic li,
            input logic rh, input logic tl, input logic pr, input logic pw, input logic as);
        return {rsp, ww, dl, di, ll, li, rh, tl, pr, pw, as};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; hit = 0; hit_way = 0; lru_way = 0;
        victim_valid = 0; victim_dirty = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    // ---------------- table of COMPARE-cycle vectors -----------------------
    typedef struct {
        logic       rd, wr, ht, hway, drop;
        logic       rsp;
        logic [1:0] ww;
        logic       dl, di, ll, li;
        logic [3:0] hc;
    } vec_t;

    vec_t vecs [6];

    // ---------------- behavioural cache (datapath stand-in + golden) -------
    logic       dp_v [4][2];
    logic [1:0] dp_t [4][2];
    logic       dp_d [4][2];
    logic       dp_lru [4];
    logic       g_v [4][2];
    logic [1:0] g_t [4][2];
    logic       g_d [4][2];
    int         g_lru [4];
    int         g_hits, g_misses, g_wbs;

    function automatic int sat(input int x);
        return (x > MAX) ? MAX : x;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < 4; s++) begin
            dp_lru[s] = 0; g_lru[s] = 0;
            for (int k = 0; k < 2; k++) begin
                dp_v[s][k] = 0; dp_t[s][k] = 0; dp_d[s][k] = 0;
                g_v[s][k]  = 0; g_t[s][k]  = 0; g_d[s][k]  = 0;
            end
        end
        g_hits = 0; g_misses = 0; g_wbs = 0;
    endtask

    task automatic drive_dp(input int idx, input logic [1:0] tg);
        hit = 0; hit_way = 0;
        for (int k = 0; k < 2; k++) begin
            if (dp_v[idx][k] && dp_t[idx][k] == tg) begin
                hit = 1; hit_way = 1'(k);
            end
        end
        lru_way      = dp_lru[idx];
        victim_valid = dp_v[idx][lru_way];
        victim_dirty = dp_d[idx][lru_way];
    endtask

    task automatic run_txn(input int idx, input logic [1:0] tg, input logic wr,
                           input int lf, input int lw);
        logic ghit, rdb, done;
        int   w, exp_lat, cnt, pc;
        // expected outcome from plain cache rules
        ghit = 0; w = 0;
        for (int k = 0; k < 2; k++) begin
            if (g_v[idx][k] && g_t[idx][k] == tg) begin ghit = 1; w = k; end
        end
        if (ghit) begin
            exp_lat = 2; g_hits++;
        end else begin
            w = g_lru[idx]; g_misses++;
            exp_lat = 3 + lf;
            if (g_v[idx][w] && g_d[idx][w]) begin exp_lat += lw; g_wbs++; end
            g_v[idx][w] = 1; g_t[idx][w] = tg; g_d[idx][w] = 0;
        end
        if (wr) g_d[idx][w] = 1;
        g_lru[idx] = 1 - w;

        rdb  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        cnt  = 0; pc = 0; done = 0;
        while (!done && cnt < 60) begin
            step();
            cnt++;
            mem_read = rdb; mem_write = wr;
            drive_dp(idx, tg);
            pmem_resp = 0;
            #1;
            if (pmem_read || pmem_write) begin
                pc++;
                if (pc == (pmem_write ? lw : lf)) pmem_resp = 1;
            end
            settle();
            if (pmem_write) check("wb_addr_sel", 32'(pmem_addr_sel), 32'd1);
            if (pmem_read)  check("fill_route_sel", 32'({route_hit, pmem_addr_sel}), 32'd0);
            if (mem_resp) done = 1;
            // array side effects of this cycle's enables
            if (tag_load) begin dp_t[idx][lru_way] = tg; dp_v[idx][lru_way] = 1; end
            if (dirty_load) dp_d[idx][tag_load ? lru_way : hit_way] = dirty_in;
            if (lru_load) dp_lru[idx] = lru_in;
            if (pmem_resp) pc = 0;
        end
        if (!done) check("txn_timeout", 32'd0, 32'd1);
        check("txn_latency", 32'(cnt), 32'(exp_lat));
        step();
        clear_inputs();
        settle();
        check("txn_single_resp", 32'(mem_resp), 32'd0);
        check("rand_hit_count",  32'(hit_count),  32'(sat(g_hits)));
        check("rand_miss_count", 32'(miss_count), 32'(sat(g_misses)));
        check("rand_wb_count",   32'(wb_count),   32'(sat(g_wbs)));
        check("rand_line_state",
              32'({dp_v[idx][1], dp_t[idx][1], dp_d[idx][1],
                   dp_v[idx][0], dp_t[idx][0], dp_d[idx][0], dp_lru[idx]}),
              32'({g_v[idx][1], g_t[idx][1], g_d[idx][1],
                   g_v[idx][0], g_t[idx][0], g_d[idx][0], (g_lru[idx] == 1)}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nresp;
        logic [11:0] idle_v;

        //            rd wr ht hw dr rsp ww    dl di ll li hc
        vecs[0] = '{1, 0, 1, 1, 0, 1, 2'b00, 0, 0, 1, 0, 4'd1};
        vecs[1] = '{1, 0, 1, 0, 0, 1, 2'b00, 0, 0, 1, 1, 4'd1};
        vecs[2] = '{0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 1, 4'd1};
        vecs[3] = '{0, 1, 1, 1, 0, 1, 2'b10, 1, 1, 1, 0, 4'd1};
        vecs[4] = '{1, 1, 1, 1, 0, 1, 2'b10, 1, 1, 1, 0, 4'd1};
        vecs[5] = '{1, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 4'd0};

        idle_v = expv(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // reset state
        do_reset();
        settle();
        check("reset_outputs", 32'(outs()), 32'(idle_v));
        check("reset_counters", 32'({hit_count, miss_count, wb_count}), 32'd0);

        // table-driven COMPARE-cycle behaviour
        for (int i = 0; i < 6; i++) begin
            do_reset();
            step();
            mem_read = vecs[i].rd; mem_write = vecs[i].wr;
            settle();
            check($sformatf("vec%0d_idle_outs", i), 32'(outs()), 32'(idle_v));
            step();
            if (vecs[i].drop) begin mem_read = 0; mem_write = 0; end
            hit = vecs[i].ht; hit_way = vecs[i].hway;
            settle();
            check($sformatf("vec%0d_compare_outs", i), 32'(outs()),
                  32'(expv(vecs[i].rsp, vecs[i].ww, vecs[i].dl, vecs[i].di,
                           vecs[i].ll, vecs[i].li, 1, 0, 0, 0, 0)));
            step();
            clear_inputs();
            settle();
            check($sformatf("vec%0d_after_outs", i), 32'(outs()), 32'(idle_v));
            check($sformatf("vec%0d_hit_count", i), 32'(hit_count), 32'(vecs[i].hc));
            check($sformatf("vec%0d_miss_count", i), 32'(miss_count), 32'd0);
        end

        // clean miss, lru_way=1, fill takes 5 cycles
        do_reset();
        step();
        mem_read = 1; lru_way = 1; victim_valid = 1; victim_dirty = 0;
        settle();
        step();
        settle();
        check("clean_compare_outs", 32'(outs()), 32'(idle_v));
        for (int i = 0; i < 5; i++) begin
            step();
            pmem_resp = (i == 4);
            settle();
            if (i < 4)
                check("clean_fill_wait", 32'(outs()), 32'(expv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
            else
                check("clean_fill_done", 32'(outs()), 32'(expv(0, 2'b10, 1, 0, 0, 0, 0, 1, 1, 0, 0)));
        end
        step();
        pmem_resp = 0; hit = 1; hit_way = 1;
        settle();
        check("clean_recompare", 32'(outs()), 32'(expv(1, 2'b00, 0, 0, 1, 0, 1, 0, 0, 0, 0)));
        step();
        clear_inputs();
        settle();
        check("clean_counts", 32'({hit_count, miss_count, wb_count}), 32'({4'd0, 4'd1, 4'd0}));

        // dirty miss: writeback 3 cycles, fill 2 cycles, lru_way=0
        do_reset();
        step();
        mem_read = 1; lru_way = 0; victim_valid = 1; victim_dirty = 1;
        settle();
        step();
        settle();
        for (int i = 0; i < 3; i++) begin
            step();
            pmem_resp = (i == 2);
            settle();
            check("dirty_wb_outs", 32'(outs()), 32'(expv(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 1)));
        end
        for (int i = 0; i < 2; i++) begin
            step();
            pmem_resp = (i == 1);
            victim_dirty = 0;
            settle();
            if (i == 1)
                check("dirty_fill_done", 32'(outs()), 32'(expv(0, 2'b01, 1, 0, 0, 0, 0, 1, 1, 0, 0)));
            else
                check("dirty_fill_wait", 32'(outs()), 32'(expv(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
        end
        step();
        pmem_resp = 0; hit = 1; hit_way = 0;
        settle();
        check("dirty_recompare", 32'(outs()), 32'(expv(1, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0)));
        step();
        clear_inputs();
        settle();
        check("dirty_counts", 32'({hit_count, miss_count, wb_count}), 32'({4'd0, 4'd1, 4'd1}));

        // saturation: 20 back-to-back hits on a 4-bit counter
        do_reset();
        nresp = 0;
        step();
        mem_read = 1; hit = 1; hit_way = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (mem_resp) nresp++;
            step();
        end
        clear_inputs();
        settle();
        check("sat_resp_pulses", 32'(nresp), 32'd20);
        check("sat_hit_count", 32'(hit_count), 32'd15);
        check("sat_miss_count", 32'(miss_count), 32'd0);

        // reset asserted while filling
        do_reset();
        step();
        mem_read = 1;
        settle();
        step();
        settle();
        step();
        settle();
        check("rstfill_in_fill", 32'({pmem_read, miss_count}), 32'({1'b1, 4'd1}));
        step();
        reset = 1; mem_read = 0;
        settle();
        step();
        reset = 0;
        settle();
        check("rstfill_outs", 32'(outs()), 32'(idle_v));
        check("rstfill_counts", 32'({hit_count, miss_count, wb_count}), 32'd0);
        step();
        mem_read = 1; hit = 1; hit_way = 1;
        settle();
        check("rstfill_req_idle", 32'(mem_resp), 32'd0);
        step();
        settle();
        check("rstfill_req_resp", 32'(mem_resp), 32'd1);
        step();
        clear_inputs();
        settle();
        check("rstfill_hit_count", 32'(hit_count), 32'd1);

        // random accesses against the behavioural cache
        do_reset();
        clear_model();
        for (int t = 0; t < 60; t++) begin
            run_txn(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Control FSM for the 2-way set-associative L2 cache.
- Sits directly upstream of l2_routing_unit and the L2 data/tag arrays. It drives that unit's hit and way-write enables, sequences dirty-victim writeback and line fill over the physical-memory handshake, and returns mem_resp to the L1 side.
- Also keeps saturating hit/miss/writeback counters for performance debug.

Parameters:
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  L1-side read request, held until mem_resp.
- mem_write  in  1  L1-side write request (128-bit chunk), held until mem_resp.
- hit  in  1  tag match on either valid way (datapath compare).
- hit_way  in  1  way that matched; valid only when hit=1.
- lru_way  in  1  current LRU (victim) way of the indexed set.
- victim_valid  in  1  valid bit of the LRU way.
- victim_dirty  in  1  dirty bit of the LRU way.
- pmem_resp  in  1  physical-memory completion pulse.
- route_hit  out  1  drives l2_routing_unit hit; 0 selects pmem_rdata.
- way_write  out  2  one-hot data-array write enable per way.
- tag_load  out  1  load tag/valid of lru_way.
- dirty_load  out  1  load dirty bit of the selected way.
- dirty_in  out  1  value written with dirty_load.
- lru_load  out  1  update LRU bit of the set.
- lru_in  out  1  new LRU value: the way not just used.
- pmem_addr_sel  out  1  0 = request address; 1 = victim tag + index.
- pmem_read  out  1  physical-memory read request.
- pmem_write  out  1  physical-memory write request (victim line).
- mem_resp  out  1  one-cycle completion to L1.
- hit_count, miss_count, wb_count  out  CNT_WIDTH  saturating statistics.

Behaviour:
- States: IDLE, COMPARE, WRITEBACK, FILL. Reset goes to IDLE.
- Outputs are Moore/Mealy combinational from state plus inputs. Every output defaults to 0 in every state unless listed below. route_hit defaults to 1.
- IDLE: if mem_read|mem_write, go to COMPARE the next cycle. This gives the arrays one cycle of registered read.
- COMPARE with no request: go to IDLE; no side effects.
- COMPARE with hit=1:
  - Assert mem_resp, lru_load, lru_in=~hit_way.
  - On a write, also assert way_write[hit_way], dirty_load, dirty_in=1. route_hit=1, so the chunk merges per bit4.
  - Increment hit_count. Go to IDLE.
- COMPARE with hit=0:
  - Increment miss_count.
  - If victim_valid & victim_dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - pmem_write=1, pmem_addr_sel=1, held until pmem_resp.
  - On pmem_resp: increment wb_count, go to FILL.
- FILL:
  - pmem_read=1, pmem_addr_sel=0, route_hit=0, held until pmem_resp.
  - On pmem_resp, in the same cycle: way_write[lru_way]=1, tag_load=1, dirty_load=1, dirty_in=0. Go to COMPARE; the re-compare hits and completes the access, including any write merge.
- Total latency:
  - hit: 2 cycles from request to mem_resp.
  - clean miss: 3 cycles plus pmem latency.
  - dirty miss: adds one further pmem transaction.
- mem_read and mem_write both asserted: treated as a write.
- Request dropped during WRITEBACK or FILL: the pmem transaction still completes, since pmem cannot be aborted. COMPARE then sees no request and returns to IDLE. The filled line remains valid and clean.
- pmem_resp in IDLE or COMPARE: ignored.
- mem_resp is never asserted outside COMPARE; it is high for exactly one cycle per access.
- Counters:
  - Increment by 1 and saturate at all-ones; no wrap.
  - hit_count counts only first-pass hits; the re-compare after FILL counts as neither hit nor miss. The FSM tracks this with a 1-bit refill flag, set on FILL→COMPARE and cleared in IDLE.
- Reset mid-operation: next cycle state=IDLE, pmem_read=pmem_write=0, all counters=0, refill flag=0.

Decomposition:
- Shared lc3b_types package: add an enum type lc3b_l2_state {IDLE, COMPARE, WRITEBACK, FILL}. Reuse lc3b_chunk and lc3b_full_chunk unchanged.
- Sub-module sat_counter (parameter width; ports clk, reset, inc, count), instantiated three times.

Test Plan:
- Read hit, way 1: hit=1, hit_way=1 → mem_resp on cycle 2, lru_in=0, way_write=00, hit_count=1, miss_count=0.
- Write hit, way 0 → way_write=01, dirty_in=1, route_hit=1, mem_resp one cycle, lru_in=1.
- Clean miss: victim_dirty=0, lru_way=1, pmem_resp after 5 cycles → pmem_read 5 cycles with route_hit=0, then way_write=10 + tag_load, re-compare mem_resp. hit_count=0, miss_count=1.
- Dirty miss → WRITEBACK with pmem_addr_sel=1 until pmem_resp, wb_count=1, then FILL with pmem_addr_sel=0, then mem_resp.
- Saturation: CNT_WIDTH=4, 20 hits → hit_count holds 15.
- Reset asserted during FILL → next cycle pmem_read=0, state IDLE, counters 0. A request after reset completes normally.
